// File: rtl/spram_arbiter_if.sv
// rtl/spram_arbiter_if.sv - CPU/aux requester and SPRAM pin bundle for spram_arbiter
interface spram_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;

    logic          aux_req;
    logic          aux_we;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_wdata;
    logic          aux_gnt;
    logic [DW-1:0] aux_rdata;
    logic          aux_rvalid;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wen;
    logic [3:0]    ram_maskwren;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        output aux_gnt, aux_rdata, aux_rvalid,
        output ram_addr, ram_wdata, ram_wen, ram_maskwren,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output aux_req, aux_we, aux_addr, aux_wdata,
        input  aux_gnt, aux_rdata, aux_rvalid,
        input  ram_addr, ram_wdata, ram_wen, ram_maskwren,
        output ram_rdata
    );
endinterface

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - CPU-priority SPRAM arbiter with aux starvation guard
// Optional stall/force statistics counters under SPRAM_ARB_STATS_EN.
module spram_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int AW       = 14,
    parameter int DW       = 16
) (
    input  logic                 clk_cpu,
    input  logic                 rst,
    spram_arbiter_if.slave       bus
`ifdef SPRAM_ARB_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [15:0]          stat_stall,
    output logic [15:0]          stat_aux_force
`endif
);
    typedef enum logic {NORMAL, FORCE} state_t;

    state_t        state, state_next;
    logic [7:0]    wait_cnt, wait_next;
    logic          cpu_gnt, aux_gnt_c;

    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;
    logic          ram_wen_q;

    logic          tag0_v, tag0_aux, tag1_v, tag1_aux;

    always_comb begin
        state_next = state;
        wait_next  = 8'd0;
        cpu_gnt    = 1'b0;
        aux_gnt_c  = 1'b0;
        if (state == FORCE && bus.aux_req)
            aux_gnt_c = 1'b1;
        else if (bus.cpu_req)
            cpu_gnt = 1'b1;
        else if (bus.aux_req)
            aux_gnt_c = 1'b1;

        if (bus.aux_req && !aux_gnt_c)
            wait_next = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

        case (state)
            NORMAL:  if (bus.aux_req && !aux_gnt_c && wait_next == 8'(MAX_WAIT))
                         state_next = FORCE;
            FORCE:   if (aux_gnt_c || !bus.aux_req)
                         state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    assign bus.cpu_stall = bus.cpu_req && !cpu_gnt;
    assign bus.aux_gnt   = aux_gnt_c;

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            state    <= NORMAL;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // SPRAM pins are registered; address/data hold when nothing is granted.
    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wen_q   <= 1'b0;
        end else if (cpu_gnt) begin
            ram_addr_q  <= bus.cpu_addr;
            ram_wdata_q <= bus.cpu_wdata;
            ram_wen_q   <= bus.cpu_we;
        end else if (aux_gnt_c) begin
            ram_addr_q  <= bus.aux_addr;
            ram_wdata_q <= bus.aux_wdata;
            ram_wen_q   <= bus.aux_we;
        end else begin
            ram_wen_q   <= 1'b0;
        end
    end

    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_wdata    = ram_wdata_q;
    assign bus.ram_wen      = ram_wen_q;
    assign bus.ram_maskwren = {4{ram_wen_q}};

    // Stage 0 covers the pin register, stage 1 the SPRAM output register.
    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            tag0_v   <= 1'b0;
            tag0_aux <= 1'b0;
            tag1_v   <= 1'b0;
            tag1_aux <= 1'b0;
        end else begin
            tag0_v   <= (cpu_gnt && !bus.cpu_we) || (aux_gnt_c && !bus.aux_we);
            tag0_aux <= aux_gnt_c;
            tag1_v   <= tag0_v;
            tag1_aux <= tag0_aux;
        end
    end

    assign bus.cpu_rdata  = bus.ram_rdata;
    assign bus.aux_rdata  = bus.ram_rdata;
    assign bus.cpu_rvalid = tag1_v && !tag1_aux;
    assign bus.aux_rvalid = tag1_v && tag1_aux;

`ifdef SPRAM_ARB_STATS_EN
    logic [15:0] stall_q, force_q;

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            stall_q <= 16'd0;
            force_q <= 16'd0;
        end else if (stat_clr) begin
            stall_q <= 16'd0;
            force_q <= 16'd0;
        end else begin
            if (bus.cpu_stall && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
            if (state == FORCE && aux_gnt_c && force_q != 16'hFFFF)
                force_q <= force_q + 16'd1;
        end
    end

    assign stat_stall     = stall_q;
    assign stat_aux_force = force_q;
`endif
endmodule
